// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types, tables and encodings for the sound-effect scheduler
//   SFX_PERIOD : clk cycles per sample for each effect, index 0 in the low bits
//   SFX_LEN    : samples per effect, index 0 in the low bits
//   SEL_*      : sound_sel encoding driven to the audio mux
package sfx_pkg;

   localparam int SFX_NUM    = 3;
   localparam int SFX_ADDR_W = 17;
   localparam int SFX_CNT_W  = 16;

   localparam logic [SFX_NUM*SFX_CNT_W-1:0]  SFX_PERIOD = {16'd22607, 16'd20800, 16'd22706};
   localparam logic [SFX_NUM*SFX_ADDR_W-1:0] SFX_LEN    = {17'd88200, 17'd44100, 17'd2158};

   typedef logic [1:0] sfx_id_t;

   localparam logic [1:0] SEL_NONE          = 2'd0;
   localparam logic [1:0] SEL_CHOMP         = 2'd1;
   localparam logic [1:0] SEL_PORTAL_PLACE  = 2'd2;
   localparam logic [1:0] SEL_PORTAL_TRAVEL = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } sfx_state_t;

endpackage

// File: rtl/sfx_sample_timer.sv
// rtl/sfx_sample_timer.sv - loadable sample-period counter
//   clk_i/rst_ni  : clock, asynchronous active-low reset
//   clear_i       : force the count back to zero on the next edge
//   period_i      : clk cycles per sample (must be >= 2)
//   sample_stb_o  : high during the last cycle of each sample period
module sfx_sample_timer import sfx_pkg::*; #(
   parameter int CNT_W = SFX_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             sample_stb_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Equality compare only: the count wraps at period-1 and can never run past it.
   assign sample_stb_o = (cnt_q == period_i - CNT_W'(1));

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_i || sample_stb_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - fixed-priority one-shot sequencer for the sound-effect ROMs
//   clk_i/rst_ni  : clock, asynchronous active-low reset
//   req_i         : one-cycle play request per effect (highest index wins)
//   stop_i        : abort playback and drop everything pending
//   rom_addr_o    : shared sample address for the selected ROM
//   sample_stb_o  : one-cycle pulse in the cycle rom_addr advances (or the last sample ends)
//   sound_sel_o   : 0 = silence, i+1 = effect i playing
//   active_o      : an effect is playing
//   pending_o     : queued requests
//   done_o        : one-cycle pulse after an effect finished its last sample naturally
module sfx_scheduler import sfx_pkg::*; #(
   parameter int                          NUM_SFX    = SFX_NUM,
   parameter int                          ADDR_W     = SFX_ADDR_W,
   parameter int                          CNT_W      = SFX_CNT_W,
   parameter logic [NUM_SFX*CNT_W-1:0]    PERIOD_TBL = SFX_PERIOD,
   parameter logic [NUM_SFX*ADDR_W-1:0]   LEN_TBL    = SFX_LEN
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_SFX-1:0] req_i,
   input  logic               stop_i,
   output logic [ADDR_W-1:0]  rom_addr_o,
   output logic               sample_stb_o,
   output logic [1:0]         sound_sel_o,
   output logic               active_o,
   output logic [NUM_SFX-1:0] pending_o,
   output logic               done_o
);

   sfx_state_t         state_q, state_d;
   logic [NUM_SFX-1:0] pending_q, pending_d, win_mask, cur_mask;
   sfx_id_t            cur_q, cur_d, win;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d, len_sel;
   logic [CNT_W-1:0]   period_sel;
   logic [1:0]         sound_sel_q, sound_sel_d;
   logic               done_q, done_d;
   logic               any_pend, tick, finish, grant, retrig, tmr_clear;

   // Priority encoder (last set bit in ascending order is the highest index)
   // and per-effect table lookup for the effect currently owning the output.
   always_comb begin
      win        = '0;
      period_sel = PERIOD_TBL[CNT_W-1:0];
      len_sel    = LEN_TBL[ADDR_W-1:0];
      for (int i = 0; i < NUM_SFX; i++) begin
         if (pending_q[i]) begin
            win = sfx_id_t'(i);
         end
         if (cur_q == sfx_id_t'(i)) begin
            period_sel = PERIOD_TBL[i*CNT_W +: CNT_W];
            len_sel    = LEN_TBL[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign any_pend = |pending_q;
   assign win_mask = NUM_SFX'(1) << win;
   assign cur_mask = NUM_SFX'(1) << cur_q;

   sfx_sample_timer #(.CNT_W(CNT_W)) u_timer (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (tmr_clear),
      .period_i     (period_sel),
      .sample_stb_o (tick)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. Grants only ever come from already-registered pending bits,
   // so a request takes one edge to queue and one more to start.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      finish  = 1'b0;
      retrig  = 1'b0;
      if (stop_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_pend) begin
                  grant   = 1'b1;
                  state_d = ST_PLAY;
               end
            end
            ST_PLAY: begin
               finish = tick && (rom_addr_q == len_sel - ADDR_W'(1));
               // A natural end and a preemption in the same cycle collapse into one grant.
               if (any_pend && (finish || win > cur_q)) begin
                  grant = 1'b1;
               end else if (finish) begin
                  state_d = ST_IDLE;
               end else if ((req_i & cur_mask) != '0) begin
                  retrig = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs and datapath next values
   always_comb begin
      pending_d   = pending_q | req_i;
      cur_d       = cur_q;
      rom_addr_d  = rom_addr_q;
      sound_sel_d = sound_sel_q;
      done_d      = finish;
      if (stop_i) begin
         pending_d   = '0;
         rom_addr_d  = '0;
         sound_sel_d = SEL_NONE;
      end else if (grant) begin
         pending_d   = (pending_q & ~win_mask) | req_i;
         cur_d       = win;
         rom_addr_d  = '0;
         sound_sel_d = win + 2'd1;
      end else if (state_d == ST_IDLE) begin
         rom_addr_d  = '0;
         sound_sel_d = SEL_NONE;
      end else if (retrig) begin
         // Restart in place; the request is consumed rather than queued.
         pending_d   = pending_q | (req_i & ~cur_mask);
         rom_addr_d  = '0;
      end else if (tick) begin
         rom_addr_d  = rom_addr_q + ADDR_W'(1);
      end
   end

   assign tmr_clear    = grant || retrig || (state_d == ST_IDLE);
   assign sample_stb_o = tick && (state_q == ST_PLAY) && !stop_i && !retrig && (finish || !grant);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q   <= '0;
         cur_q       <= '0;
         rom_addr_q  <= '0;
         sound_sel_q <= SEL_NONE;
         done_q      <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         cur_q       <= cur_d;
         rom_addr_q  <= rom_addr_d;
         sound_sel_q <= sound_sel_d;
         done_q      <= done_d;
      end
   end

   assign rom_addr_o  = rom_addr_q;
   assign sound_sel_o = sound_sel_q;
   assign active_o    = (state_q == ST_PLAY);
   assign pending_o   = pending_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - scoreboard bench for sfx_scheduler with a cycle-level effect model
module tb_sfx_scheduler;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic        stop;
   logic [16:0] rom_addr;
   logic        sample_stb;
   logic [1:0]  sound_sel;
   logic        active;
   logic [2:0]  pending;
   logic        done;

   sfx_scheduler #(
      .NUM_SFX    (3),
      .ADDR_W     (17),
      .CNT_W      (16),
      .PERIOD_TBL ({16'd4, 16'd4, 16'd4}),
      .LEN_TBL    ({17'd8, 17'd6, 17'd5})
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req),
      .stop_i       (stop),
      .rom_addr_o   (rom_addr),
      .sample_stb_o (sample_stb),
      .sound_sel_o  (sound_sel),
      .active_o     (active),
      .pending_o    (pending),
      .done_o       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        stb;
      logic [16:0] addr;
      logic [1:0]  sel;
      logic        act;
      logic [2:0]  pend;
      logic        done;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: what is playing, which sample, how far into that sample.
   int   PER[3] = '{4, 4, 4};
   int   LEN[3] = '{5, 6, 8};
   bit   m_play;
   int   m_cur, m_pos, m_phase;
   logic [2:0] m_pend;
   bit   m_done;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start(input int id);
      m_play  = 1'b1;
      m_cur   = id;
      m_pos   = 0;
      m_phase = 0;
   endtask

   // Drive one cycle of stimulus just after the edge and push what the DUT must
   // show for the rest of this cycle; then advance the model across the next edge.
   task automatic step(input logic [2:0] r, input logic s, input logic rn);
      exp_t e;
      int   hi;
      bit   last, stb;
      logic [2:0] r2;
      @(posedge clk);
      #1;
      req   = r;
      stop  = s;
      rst_n = rn;
      if (!rn) begin
         m_play = 0; m_cur = 0; m_pos = 0; m_phase = 0; m_pend = '0; m_done = 0;
         e = '0;
         q.push_back(e);
         return;
      end
      e.addr = 17'(m_pos);
      e.sel  = m_play ? 2'(m_cur + 1) : 2'd0;
      e.act  = m_play;
      e.pend = m_pend;
      e.done = m_done;
      hi = -1;
      for (int i = 0; i < 3; i++) if (m_pend[i]) hi = i;
      last   = m_play && (m_phase == PER[m_cur] - 1) && (m_pos == LEN[m_cur] - 1);
      stb    = 0;
      m_done = 0;
      if (s) begin
         m_play = 0; m_pos = 0; m_phase = 0; m_pend = '0;
      end else if (!m_play) begin
         if (hi >= 0) begin
            m_pend[hi] = 1'b0;
            start(hi);
         end
         m_pend |= r;
      end else begin
         m_done = last;
         if (hi >= 0 && (last || hi > m_cur)) begin
            stb = last;
            m_pend[hi] = 1'b0;
            m_pend |= r;
            start(hi);
         end else if (last) begin
            stb = 1;
            m_play = 0; m_pos = 0; m_phase = 0;
            m_pend |= r;
         end else if (r[m_cur]) begin
            m_pos = 0; m_phase = 0;
            r2 = r;
            r2[m_cur] = 1'b0;
            m_pend |= r2;
         end else begin
            if (m_phase == PER[m_cur] - 1) begin
               stb = 1;
               m_phase = 0;
               m_pos++;
            end else begin
               m_phase++;
            end
            m_pend |= r;
         end
      end
      e.stb = stb;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(3'b000, 1'b0, 1'b1);
   endtask

   // Monitor: compares whatever the driver queued for this cycle, mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sample_stb", int'(sample_stb), int'(e.stb));
            check("rom_addr",   int'(rom_addr),   int'(e.addr));
            check("sound_sel",  int'(sound_sel),  int'(e.sel));
            check("active",     int'(active),     int'(e.act));
            check("pending",    int'(pending),    int'(e.pend));
            check("done",       int'(done),       int'(e.done));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      req   = '0;
      stop  = 1'b0;
      m_play = 0; m_cur = 0; m_pos = 0; m_phase = 0; m_pend = '0; m_done = 0;
      step(3'b000, 1'b0, 1'b0);
      step(3'b000, 1'b0, 1'b0);
      idle(2);
      // single play
      step(3'b001, 1'b0, 1'b1); idle(30);
      // retrigger while playing
      step(3'b001, 1'b0, 1'b1); idle(10);
      step(3'b001, 1'b0, 1'b1); idle(40);
      // preempt idx0 at rom_addr 2
      step(3'b001, 1'b0, 1'b1); idle(10);
      step(3'b100, 1'b0, 1'b1); idle(40);
      // same-cycle priority queue
      step(3'b011, 1'b0, 1'b1); idle(60);
      // stop with a pending request and a same-cycle request
      step(3'b010, 1'b0, 1'b1); idle(3);
      step(3'b001, 1'b0, 1'b1); idle(5);
      step(3'b100, 1'b1, 1'b1); idle(5);
      // asynchronous reset mid-play, then replay
      step(3'b010, 1'b0, 1'b1); idle(14);
      step(3'b000, 1'b0, 1'b0);
      step(3'b000, 1'b0, 1'b0);
      step(3'b010, 1'b0, 1'b1); idle(40);
      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         logic [2:0] r;
         logic       s, rn;
         r  = ($urandom_range(0, 14) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
         s  = ($urandom_range(0, 199) == 0);
         rn = !($urandom_range(0, 599) == 0);
         step(r, s, rn);
      end
      idle(5);
      @(negedge clk);
      #1;
      check("queue_drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
